// File: rtl/gh_door_controller.sv
// Greenhouse door motor sequencer: registered Moore FSM driven by the two PIR
// sensors, the two limit switches and the climate lock, with hold and motor timers.
module gh_door_controller #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int MOTOR_TIMEOUT = 5000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       door_pir_in,
    input  logic       door_pir_out,
    input  logic       door_open_max,
    input  logic       door_close_max,
    input  logic       lock_req,
    input  logic       clear_fault,
    output logic       door_open,
    output logic       door_close,
    output logic [2:0] door_state,
    output logic       fault
);

    // state     | meaning
    // CLOSED    | door shut, motor idle; waits for presence or homes if not at close limit
    // OPENING   | motor driving open until the open limit switch
    // OPEN_HOLD | door open, hold timer running, restarted by presence
    // CLOSING   | motor driving closed; presence reverses to OPENING
    // FAULT     | motor timeout or limit-switch conflict; left only by clear_fault
    typedef enum logic [2:0] {
        S_CLOSED    = 3'd0,
        S_OPENING   = 3'd1,
        S_OPEN_HOLD = 3'd2,
        S_CLOSING   = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOTOR_TC = CNT_W'(MOTOR_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic             presence;
    logic             sensor_conflict;
    logic             hold_done;
    logic             motor_expired;
    logic             timer_run;

    assign presence        = door_pir_in | door_pir_out;
    assign sensor_conflict = door_open_max & door_close_max;
    assign hold_done       = (timer == HOLD_TC);
    assign motor_expired   = (timer == MOTOR_TC);
    assign timer_run       = (state == S_OPENING) || (state == S_OPEN_HOLD) ||
                             (state == S_CLOSING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLOSED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            // Any state change restarts the timer so each state measures its own dwell time.
            if (state_nxt != state) begin
                timer <= '0;
            end else if ((state == S_OPEN_HOLD) && presence) begin
                timer <= '0;
            end else if (timer_run && (timer != CNT_MAX)) begin
                timer <= timer + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLOSED: begin
                if (sensor_conflict)                   state_nxt = S_FAULT;
                else if (presence && !lock_req)        state_nxt = S_OPENING;
                else if (!door_close_max && !lock_req) state_nxt = S_CLOSING;
            end
            S_OPENING: begin
                if (sensor_conflict)    state_nxt = S_FAULT;
                else if (door_open_max) state_nxt = S_OPEN_HOLD;
                else if (motor_expired) state_nxt = S_FAULT;
            end
            S_OPEN_HOLD: begin
                if (sensor_conflict)            state_nxt = S_FAULT;
                else if (lock_req && !presence) state_nxt = S_CLOSING;
                else if (hold_done)             state_nxt = S_CLOSING;
            end
            S_CLOSING: begin
                // Reversal on presence beats lock_req and the close limit for safety.
                if (sensor_conflict)     state_nxt = S_FAULT;
                else if (presence)       state_nxt = S_OPENING;
                else if (door_close_max) state_nxt = S_CLOSED;
                else if (motor_expired)  state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (clear_fault) state_nxt = S_CLOSED;
            end
            default: state_nxt = S_FAULT;
        endcase
    end

    always_comb begin
        door_open  = 1'b0;
        door_close = 1'b0;
        fault      = 1'b0;
        door_state = state;
        case (state)
            S_OPENING: door_open  = 1'b1;
            S_CLOSING: door_close = 1'b1;
            S_FAULT:   fault      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gh_door_controller.sv
// Directed self-checking bench for gh_door_controller with short timers
// (hold 8 cycles, motor timeout 20 cycles).
module tb_gh_door_controller;

    localparam int HOLD = 8;
    localparam int TMO  = 20;

    logic       clk;
    logic       rst_n;
    logic       door_pir_in;
    logic       door_pir_out;
    logic       door_open_max;
    logic       door_close_max;
    logic       lock_req;
    logic       clear_fault;
    logic       door_open;
    logic       door_close;
    logic [2:0] door_state;
    logic       fault;

    int checks;
    int passes;

    gh_door_controller #(
        .HOLD_CYCLES  (HOLD),
        .MOTOR_TIMEOUT(TMO),
        .CNT_W        (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .door_pir_in   (door_pir_in),
        .door_pir_out  (door_pir_out),
        .door_open_max (door_open_max),
        .door_close_max(door_close_max),
        .lock_req      (lock_req),
        .clear_fault   (clear_fault),
        .door_open     (door_open),
        .door_close    (door_close),
        .door_state    (door_state),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        door_pir_in    = 1'b0;
        door_pir_out   = 1'b0;
        door_open_max  = 1'b0;
        door_close_max = 1'b1;
        lock_req       = 1'b0;
        clear_fault    = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        door_pir_in    = 1'b0;
        door_pir_out   = 1'b0;
        door_open_max  = 1'b0;
        door_close_max = 1'b1;
        lock_req       = 1'b0;
        clear_fault    = 1'b0;
        rst_n          = 1'b0;
        #3;
        checks++;
        if ({door_open, door_close, fault, door_state} !== 6'b000_000)
            $display("FAIL reset_outputs: got %b expected 000000", {door_open, door_close, fault, door_state});
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (door_state !== 3'd0)
            $display("FAIL reset_idle_closed: got state %0d expected 0", door_state);
        else passes++;
    endtask

    task automatic test_open_hold_close();
        int hold_cnt;
        do_reset();
        door_pir_in = 1'b1;
        tick();
        door_pir_in = 1'b0;
        door_close_max = 1'b0;
        checks++;
        if (door_open !== 1'b1 || door_state !== 3'd1)
            $display("FAIL open_start: got open=%b state=%0d expected open=1 state=1", door_open, door_state);
        else passes++;
        repeat (4) tick();
        door_open_max = 1'b1;
        tick();
        checks++;
        if (door_open !== 1'b0 || door_state !== 3'd2)
            $display("FAIL enter_hold: got open=%b state=%0d expected open=0 state=2", door_open, door_state);
        else passes++;
        hold_cnt = 0;
        for (int i = 0; i < HOLD + 4; i++) begin
            if (door_state == 3'd2) hold_cnt++;
            tick();
        end
        checks++;
        if (hold_cnt !== HOLD)
            $display("FAIL hold_length: got %0d cycles expected %0d", hold_cnt, HOLD);
        else passes++;
        // HOLD+4 sampled cycles: 8 in hold then 4 in closing; now in 5th closing cycle.
        door_open_max = 1'b0;
        checks++;
        if (door_close !== 1'b1 || door_state !== 3'd3)
            $display("FAIL closing_after_hold: got close=%b state=%0d expected close=1 state=3", door_close, door_state);
        else passes++;
        door_close_max = 1'b1;
        tick();
        checks++;
        if ({door_open, door_close, fault, door_state} !== 6'b000_000)
            $display("FAIL closed_at_limit: got %b expected 000000", {door_open, door_close, fault, door_state});
        else passes++;
    endtask

    task automatic test_reversal();
        int both_cnt;
        do_reset();
        door_close_max = 1'b0;
        lock_req = 1'b0;
        tick();
        checks++;
        if (door_state !== 3'd3)
            $display("FAIL homing_closing: got state %0d expected 3", door_state);
        else passes++;
        both_cnt = 0;
        if (door_open && door_close) both_cnt++;
        tick();
        if (door_open && door_close) both_cnt++;
        door_pir_out = 1'b1;
        tick();
        if (door_open && door_close) both_cnt++;
        checks++;
        if (door_close !== 1'b0 || door_open !== 1'b1 || door_state !== 3'd1)
            $display("FAIL reversal: got open=%b close=%b state=%0d expected open=1 close=0 state=1",
                     door_open, door_close, door_state);
        else passes++;
        door_pir_out = 1'b0;
        tick();
        if (door_open && door_close) both_cnt++;
        checks++;
        if (both_cnt !== 0)
            $display("FAIL drive_exclusive: got %0d overlap cycles expected 0", both_cnt);
        else passes++;
    endtask

    task automatic test_motor_timeout();
        int open_cnt;
        do_reset();
        door_pir_in = 1'b1;
        tick();
        door_pir_in = 1'b0;
        door_close_max = 1'b0;
        open_cnt = 0;
        for (int i = 0; i < TMO; i++) begin
            if (door_state == 3'd1) open_cnt++;
            tick();
        end
        checks++;
        if (open_cnt !== TMO)
            $display("FAIL opening_length: got %0d cycles expected %0d", open_cnt, TMO);
        else passes++;
        checks++;
        if (fault !== 1'b1 || door_open !== 1'b0 || door_state !== 3'd4)
            $display("FAIL timeout_fault: got fault=%b open=%b state=%0d expected fault=1 open=0 state=4",
                     fault, door_open, door_state);
        else passes++;
        door_close_max = 1'b1;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checks++;
        if (door_state !== 3'd0 || fault !== 1'b0)
            $display("FAIL clear_fault: got state=%0d fault=%b expected state=0 fault=0", door_state, fault);
        else passes++;
    endtask

    task automatic test_sensor_conflict();
        do_reset();
        door_pir_in = 1'b1;
        tick();
        door_pir_in = 1'b0;
        door_close_max = 1'b0;
        door_open_max = 1'b1;
        tick();
        checks++;
        if (door_state !== 3'd2)
            $display("FAIL conflict_setup: got state %0d expected 2", door_state);
        else passes++;
        door_close_max = 1'b1;
        tick();
        checks++;
        if (door_state !== 3'd4 || fault !== 1'b1)
            $display("FAIL conflict_fault: got state=%0d fault=%b expected state=4 fault=1", door_state, fault);
        else passes++;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checks++;
        if (door_state !== 3'd0)
            $display("FAIL conflict_clear: got state %0d expected 0", door_state);
        else passes++;
        tick();
        checks++;
        if (door_state !== 3'd4)
            $display("FAIL conflict_refault: got state %0d expected 4", door_state);
        else passes++;
        door_open_max = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    task automatic test_lock();
        int bad_cnt;
        do_reset();
        lock_req = 1'b1;
        door_pir_in = 1'b1;
        bad_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (door_state !== 3'd0) bad_cnt++;
        end
        checks++;
        if (bad_cnt !== 0)
            $display("FAIL lock_inhibit: got %0d non-closed cycles expected 0", bad_cnt);
        else passes++;
        lock_req = 1'b0;
        tick();
        door_close_max = 1'b0;
        lock_req = 1'b1;
        tick();
        tick();
        checks++;
        if (door_state !== 3'd1)
            $display("FAIL lock_no_abort: got state %0d expected 1", door_state);
        else passes++;
        door_open_max = 1'b1;
        tick();
        repeat (3) tick();
        checks++;
        if (door_state !== 3'd2)
            $display("FAIL lock_presence_hold: got state %0d expected 2", door_state);
        else passes++;
        door_pir_in = 1'b0;
        tick();
        checks++;
        if (door_state !== 3'd3 || door_close !== 1'b1)
            $display("FAIL lock_close: got state=%0d close=%b expected state=3 close=1", door_state, door_close);
        else passes++;
        lock_req = 1'b0;
        door_open_max = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        door_pir_in = 1'b1;
        tick();
        door_pir_in = 1'b0;
        door_close_max = 1'b0;
        tick();
        checks++;
        if (door_state !== 3'd1 || door_open !== 1'b1)
            $display("FAIL async_setup: got state=%0d open=%b expected state=1 open=1", door_state, door_open);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (door_open !== 1'b0 || door_state !== 3'd0)
            $display("FAIL async_reset: got open=%b state=%0d expected open=0 state=0", door_open, door_state);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (door_state !== 3'd3 || door_close !== 1'b1)
            $display("FAIL homing_after_reset: got state=%0d close=%b expected state=3 close=1", door_state, door_close);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_open_hold_close();
        test_reversal();
        test_motor_timeout();
        test_sensor_conflict();
        test_lock();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
